wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the in-order pipeline. It registers the instruction leaving the memory stage, waits for the load response when needed, and extracts and sign- or zero-extends load data. It drives the register file write port (address, data, enable), whose array updates on the falling clock edge. The same write is mirrored on a forwarding bus for the execute stage.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `m_valid` in 1: memory stage presents an instruction.
- `m_ready` out 1: stage accepts; transfer occurs when `m_valid && m_ready` at the rising edge.
- `m_rd` in 5: destination register.
- `m_regwrite` in 1: instruction writes `rd`.
- `m_is_load` in 1: instruction is a load.
- `m_funct3` in 3: load size/sign encoding.
- `m_addr_lo` in 2: byte offset of the load address.
- `m_result` in XLEN: ALU result or PC+4 for non-loads.
- `dmem_rvalid` in 1: data memory response valid.
- `dmem_rdata` in XLEN: raw aligned response word.
- `rf_ad` out 5: register file write address.
- `rf_wd` out XLEN: register file write data.
- `rf_we` out 1: register file write enable.
- `fwd_valid` out 1: same as `rf_we`.
- `fwd_rd` out 5: same as `rf_ad`.
- `fwd_data` out XLEN: same as `rf_wd`.
- `retire` out 1: one-cycle pulse per completed instruction.
- `retired_cnt` out 64: retired-instruction count (see Configuration).

## Operation
- States:
  - IDLE: nothing held.
  - WAIT: load accepted, awaiting `dmem_rvalid`.
  - WRITE: result final and driven this cycle.
- Accept (`m_valid && m_ready`) latches `rd`, `regwrite`, `is_load`, `funct3`, `addr_lo`, `result`.
  - Non-load goes to WRITE.
  - Load goes to WAIT.
- WAIT:
  - On `dmem_rvalid`, latch the extracted data into the result register and go to WRITE.
  - Otherwise stay in WAIT; there is no timeout.
- WRITE lasts exactly one cycle. On the next edge:
  - If a new accept occurs, go to WRITE or WAIT depending on the new instruction.
  - Otherwise go to IDLE.
- `m_ready` = `rst_n && state != WAIT`. Back-to-back non-loads therefore sustain one per cycle.
- `dmem_rvalid` outside WAIT is ignored.
- Load extraction from `dmem_rdata` (lane select by `addr_lo`):
  - 000 LB: byte `addr_lo`, sign-extended.
  - 100 LBU: byte `addr_lo`, zero-extended.
  - 001 LH: halfword `addr_lo[1]`, sign-extended.
  - 101 LHU: halfword `addr_lo[1]`, zero-extended.
  - 010 LW: full word, `addr_lo` ignored.
  - 011, 110, 111: treated as LW.
  - For halfwords, `addr_lo[0]` is ignored; no misalignment trap.
- `rf_we` = `state==WRITE && regwrite && rd!=0`. Writes to x0 are suppressed here as well as in the register file.
- `rf_ad` and `rf_wd` always reflect the held `rd` and result.
- `retire` = `state==WRITE`, including when `regwrite=0` or `rd=0`.

## Timing
- Reset values: state IDLE; all latched fields 0.
  - Outputs: `rf_we`=0, `rf_ad`=0, `rf_wd`=0, `fwd_*`=0, `retire`=0, `retired_cnt`=0.
  - `m_ready`=0 while `rst_n` is low.
- Non-load latency: accept edge N, then `rf_we` high during cycle N+1. The register file commits at the falling edge of cycle N+1.
- Load latency: `dmem_rvalid` sampled at edge M, then WRITE in cycle M+1. A response in the cycle right after the accept gives a 2-cycle minimum.
- Outputs are registered-state decodes, stable for the whole cycle including the falling edge.
- Reset during WAIT drops the load. A later `dmem_rvalid` is ignored and nothing is written.
- A simultaneous reset and accept is not captured.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - 64-bit `retired_cnt` increments on every `retire` cycle.
  - Wraps from 2^64-1 to 0.
  - Cleared by reset.
- Not defined: `retired_cnt` is tied to 0 and the counter flops are absent. The port list is unchanged.

## Structure
- Shared package `wb_pkg`:
  - `wb_state_t` enum (IDLE, WAIT, WRITE).
  - Load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- Sub-module `load_extend`: combinational lane select and extension (funct3, addr_lo, rdata → data).

## Test plan
- Reset, then non-load `rd`=5 `result`=0xDEADBEEF `regwrite`=1 → next cycle `rf_we`=1 `rf_ad`=5 `rf_wd`=0xDEADBEEF, `retire`=1; register file x5 reads 0xDEADBEEF after the falling edge.
- LB `addr_lo`=3, `rdata`=0x80FF_1234 response 3 cycles later → `m_ready`=0 while waiting; then `rf_wd`=0xFFFFFF80. Same with LBU → 0x00000080. LHU `addr_lo`=2 → 0x000080FF.
- Four back-to-back non-loads to x1..x4 → four consecutive `rf_we` cycles, `m_ready` held 1.
- Non-load `rd`=0 `regwrite`=1 → `rf_we`=0, `retire`=1; x0 stays 0.
- Load accepted, `rst_n` low before the response, `dmem_rvalid` pulsed after reset → no `rf_we`, state IDLE, `retired_cnt`=0.
- With `WB_RETIRE_CNT_EN`: 10 completed instructions → `retired_cnt`=10. Without the macro → 0.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback stage: the
//               stage state encoding and the load funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  // Writeback stage state: nothing held / load awaiting data / result driven
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

  // Load size/sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/wb_stage_if.sv
// ============================================================================
// Module      : wb_stage_if
// Description : Bundle of the memory-stage handshake, data-memory response,
//               register-file write port, forwarding bus and retire signals
//               seen by the writeback stage. The slave modport is the
//               writeback stage's view; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_stage_if #(
  parameter int XLEN = 32
);

  // Memory stage -> writeback
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic            m_regwrite;
  logic            m_is_load;
  logic [2:0]      m_funct3;
  logic [1:0]      m_addr_lo;
  logic [XLEN-1:0] m_result;

  // Data memory response
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  // Register file write port
  logic [4:0]      rf_ad;
  logic [XLEN-1:0] rf_wd;
  logic            rf_we;

  // Forwarding bus toward execute
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  // Retirement
  logic            retire;
  logic [63:0]     retired_cnt;

  modport master (
    output m_valid, m_rd, m_regwrite, m_is_load, m_funct3, m_addr_lo, m_result,
    output dmem_rvalid, dmem_rdata,
    input  m_ready,
    input  rf_ad, rf_wd, rf_we,
    input  fwd_valid, fwd_rd, fwd_data,
    input  retire, retired_cnt
  );

  modport slave (
    input  m_valid, m_rd, m_regwrite, m_is_load, m_funct3, m_addr_lo, m_result,
    input  dmem_rvalid, dmem_rdata,
    output m_ready,
    output rf_ad, rf_wd, rf_we,
    output fwd_valid, fwd_rd, fwd_data,
    output retire, retired_cnt
  );

endinterface

`default_nettype wire

// File: rtl/wb_stage_load_extend.sv
// ============================================================================
// Module      : load_extend
// Description : Combinational load lane select and sign/zero extension of
//               the raw aligned data-memory word. Unused funct3 codes are
//               treated as a full-word load; halfword bit 0 of the offset is
//               ignored (no misalignment handling).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [2:0]      i_funct3,
  input  wire logic [1:0]      i_addr_lo,
  input  wire logic [XLEN-1:0] i_rdata,
  output logic      [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes out of the word
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extend the selected lane according to the load size/sign encoding
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage of the in-order pipeline. Registers the
//               instruction leaving the memory stage, waits for the load
//               response when needed, extends load data, and drives the
//               register-file write port plus a mirrored forwarding bus.
//               Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired
//               instruction counter; without it retired_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input wire logic   clk,
  input wire logic   rst_n,
  wb_stage_if.slave  bus
);

  wb_state_t       r_state;
  wb_state_t       w_state_nxt;

  logic [4:0]      r_rd;
  logic            r_regwrite;
  logic            r_is_load;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_result;

  logic            w_ready;
  logic            w_accept;
  logic            w_write;
  logic            w_rf_we;
  logic [XLEN-1:0] w_load_data;

  // Ready is held low during reset so nothing is captured alongside it
  assign w_ready  = rst_n && (r_state != WAIT);
  assign w_accept = bus.m_valid && w_ready;
  assign w_write  = (r_state == WRITE);
  assign w_rf_we  = w_write && r_regwrite && (r_rd != 5'd0);

  // Extraction works on the held funct3/offset while waiting for the response
  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (bus.dmem_rdata),
    .o_data    (w_load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: WRITE is a single cycle and may chain directly into a new accept
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT: begin
        if (bus.dmem_rvalid && r_is_load) begin
          w_state_nxt = WRITE;
        end
      end
      default: begin
        if (w_accept) begin
          w_state_nxt = bus.m_is_load ? WAIT : WRITE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Outputs decoded from registered state only, stable through the falling edge
  always_comb begin
    bus.m_ready   = w_ready;
    bus.rf_we     = w_rf_we;
    bus.rf_ad     = r_rd;
    bus.rf_wd     = r_result;
    bus.fwd_valid = w_rf_we;
    bus.fwd_rd    = r_rd;
    bus.fwd_data  = r_result;
    bus.retire    = w_write;
  end

  // Instruction fields latch on accept; the result is replaced by load data on response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_is_load  <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_rd       <= bus.m_rd;
      r_regwrite <= bus.m_regwrite;
      r_is_load  <= bus.m_is_load;
      r_funct3   <= bus.m_funct3;
      r_addr_lo  <= bus.m_addr_lo;
      r_result   <= bus.m_result;
    end else if ((r_state == WAIT) && bus.dmem_rvalid) begin
      r_result   <= w_load_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retired_cnt;

  // Count every retiring cycle; natural wrap at 2^64
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired_cnt <= 64'd0;
    end else if (w_write) begin
      r_retired_cnt <= r_retired_cnt + 64'd1;
    end
  end

  assign bus.retired_cnt = r_retired_cnt;
`else
  assign bus.retired_cnt = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage. Includes a small
//               register-file model written on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;
  int n_retired;
  bit cnt_en;

  logic [31:0] rf_model [32];

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(
    .XLEN (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits on the falling edge; x0 writes are recorded
  // here on purpose so that any write leaking from the stage becomes visible
  always @(negedge clk) begin
    if (bus.rf_we) rf_model[bus.rf_ad] <= bus.rf_wd;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic rw,
                       input logic ld, input logic [2:0] f3, input logic [1:0] alo);
    bus.m_valid    = 1'b1;
    bus.m_rd       = rd;
    bus.m_result   = res;
    bus.m_regwrite = rw;
    bus.m_is_load  = ld;
    bus.m_funct3   = f3;
    bus.m_addr_lo  = alo;
  endtask

  // Load to x7 with the response sampled 'gap' edges after the accept edge
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] rdata, input int gap, input logic [31:0] exp);
    issue(5'd7, 32'h0000_1111, 1'b1, 1'b1, f3, alo);
    tick();
    bus.m_valid = 1'b0;
    for (int i = 0; i < gap - 1; i++) begin
      check({tag, "/wait_rdy"}, bus.m_ready, 1'b0);
      check({tag, "/wait_we"}, bus.rf_we, 1'b0);
      tick();
    end
    check({tag, "/last_wait_rdy"}, bus.m_ready, 1'b0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    check({tag, "/wd"}, bus.rf_wd, exp);
    check({tag, "/we"}, bus.rf_we, 1'b1);
    check({tag, "/ad"}, bus.rf_ad, 5'd7);
    check({tag, "/retire"}, bus.retire, 1'b1);
    n_retired++;
    tick();
    check({tag, "/after_retire"}, bus.retire, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_retired = 0;
`ifdef WB_RETIRE_CNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;

    rst_n           = 1'b0;
    bus.m_valid     = 1'b0;
    bus.m_rd        = 5'd0;
    bus.m_regwrite  = 1'b0;
    bus.m_is_load   = 1'b0;
    bus.m_funct3    = 3'd0;
    bus.m_addr_lo   = 2'd0;
    bus.m_result    = 32'h0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst/m_ready", bus.m_ready, 1'b0);
    check("rst/rf_we", bus.rf_we, 1'b0);
    check("rst/rf_ad", bus.rf_ad, 5'd0);
    check("rst/rf_wd", bus.rf_wd, 32'h0);
    check("rst/fwd_valid", bus.fwd_valid, 1'b0);
    check("rst/fwd_rd", bus.fwd_rd, 5'd0);
    check("rst/fwd_data", bus.fwd_data, 32'h0);
    check("rst/retire", bus.retire, 1'b0);
    check("rst/retired_cnt", bus.retired_cnt, 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle/m_ready", bus.m_ready, 1'b1);

    // Non-load write to x5
    issue(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    bus.m_valid = 1'b0;
    check("alu/rf_we", bus.rf_we, 1'b1);
    check("alu/rf_ad", bus.rf_ad, 5'd5);
    check("alu/rf_wd", bus.rf_wd, 32'hDEAD_BEEF);
    check("alu/fwd_valid", bus.fwd_valid, 1'b1);
    check("alu/fwd_rd", bus.fwd_rd, 5'd5);
    check("alu/fwd_data", bus.fwd_data, 32'hDEAD_BEEF);
    check("alu/retire", bus.retire, 1'b1);
    n_retired++;
    @(negedge clk);
    #1;
    check("alu/x5", rf_model[5], 32'hDEAD_BEEF);
    tick();
    check("alu/idle_retire", bus.retire, 1'b0);
    check("alu/idle_we", bus.rf_we, 1'b0);

    // Loads: lane select and extension
    do_load("lb3",  3'b000, 2'd3, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 2'd3, 32'h80FF_1234, 3, 32'h0000_0080);
    do_load("lhu2", 3'b101, 2'd2, 32'h80FF_1234, 3, 32'h0000_80FF);
    do_load("lh2",  3'b001, 2'd2, 32'h80FF_1234, 1, 32'hFFFF_80FF);
    do_load("lh1",  3'b001, 2'd1, 32'h80FF_1234, 2, 32'h0000_1234);
    do_load("lb1",  3'b000, 2'd1, 32'h80FF_1234, 1, 32'h0000_0012);
    do_load("lw",   3'b010, 2'd3, 32'h80FF_1234, 2, 32'h80FF_1234);
    do_load("f3_7", 3'b111, 2'd1, 32'hC001_D00D, 1, 32'hC001_D00D);

    // Four back-to-back non-loads to x1..x4
    for (int i = 1; i <= 4; i++) begin
      issue(i[4:0], 32'h100 * i, 1'b1, 1'b0, 3'd0, 2'd0);
      tick();
      check("b2b/rf_we", bus.rf_we, 1'b1);
      check("b2b/rf_ad", bus.rf_ad, i[4:0]);
      check("b2b/rf_wd", bus.rf_wd, 32'h100 * i);
      check("b2b/m_ready", bus.m_ready, 1'b1);
      n_retired++;
    end
    bus.m_valid = 1'b0;
    tick();
    check("b2b/end_we", bus.rf_we, 1'b0);
    check("b2b/end_retire", bus.retire, 1'b0);
    check("b2b/x3", rf_model[3], 32'h300);

    // Write to x0 is suppressed but still retires
    issue(5'd0, 32'hCAFE_F00D, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    bus.m_valid = 1'b0;
    check("x0/rf_we", bus.rf_we, 1'b0);
    check("x0/fwd_valid", bus.fwd_valid, 1'b0);
    check("x0/retire", bus.retire, 1'b1);
    n_retired++;
    @(negedge clk);
    #1;
    check("x0/reg", rf_model[0], 32'h0);

    // regwrite=0 retires without writing
    issue(5'd9, 32'h1234_5678, 1'b0, 1'b0, 3'd0, 2'd0);
    tick();
    bus.m_valid = 1'b0;
    check("norw/rf_we", bus.rf_we, 1'b0);
    check("norw/retire", bus.retire, 1'b1);
    n_retired++;
    tick();

    // Response outside WAIT is ignored
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h5555_AAAA;
    tick();
    bus.dmem_rvalid = 1'b0;
    check("stray/retire", bus.retire, 1'b0);
    check("stray/m_ready", bus.m_ready, 1'b1);
    tick();
    check("stray/retire2", bus.retire, 1'b0);
    check("cnt/mid", bus.retired_cnt, cnt_en ? 64'(n_retired) : 64'd0);

    // Reset during WAIT drops the load
    issue(5'd8, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
    tick();
    bus.m_valid = 1'b0;
    check("rstwait/m_ready", bus.m_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_retired = 0;
    #1;
    check("rstwait/m_ready_after", bus.m_ready, 1'b1);
    check("rstwait/rf_ad", bus.rf_ad, 5'd0);
    check("rstwait/cnt", bus.retired_cnt, 64'd0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    tick();
    bus.dmem_rvalid = 1'b0;
    check("rstwait/rf_we", bus.rf_we, 1'b0);
    check("rstwait/retire", bus.retire, 1'b0);
    tick();
    check("rstwait/retire2", bus.retire, 1'b0);
    check("rstwait/rf_wd", bus.rf_wd, 32'h0);
    check("rstwait/x8", rf_model[8], 32'h0);

    // Accept coinciding with reset is not captured
    rst_n = 1'b0;
    issue(5'd10, 32'hABCD_0000, 1'b1, 1'b0, 3'd0, 2'd0);
    #1;
    check("rstacc/m_ready", bus.m_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.m_valid = 1'b0;
    check("rstacc/retire", bus.retire, 1'b0);
    check("rstacc/rf_ad", bus.rf_ad, 5'd0);
    check("rstacc/rf_we", bus.rf_we, 1'b0);

    // Ten completed instructions for the retire counter
    for (int i = 0; i < 10; i++) begin
      issue(5'(i + 11), 32'(i), 1'b1, 1'b0, 3'd0, 2'd0);
      tick();
      check("cnt/retire", bus.retire, 1'b1);
      n_retired++;
    end
    bus.m_valid = 1'b0;
    tick();
    check("cnt/ten", bus.retired_cnt, cnt_en ? 64'd10 : 64'd0);
    check("cnt/tracked", bus.retired_cnt, cnt_en ? 64'(n_retired) : 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
